// File: rtl/mult32x32_stream_ctrl.sv
// mult32x32_stream_ctrl
//   Streaming wrapper around the 32x32 iterative multiplier. Operand pairs arrive over a
//   valid/ready handshake and are issued one at a time through the multiplier's start/busy
//   interface. The 64-bit products are buffered in a DEPTH-entry FIFO and leave over a second
//   valid/ready handshake.
//
// Ports
//   clk, reset                     clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b    operand pair handshake
//   in_clr_acc                     clear-accumulator flag, sampled with the operand accept
//                                  (present only with MULT_STREAM_ACC_EN)
//   mul_start/mul_a/mul_b          start pulse and registered operands to the multiplier
//   mul_busy/mul_product           multiplier status, product valid when mul_busy falls
//   out_valid/out_ready            result handshake
//   out_product/out_count          FIFO head value and FIFO occupancy
//
// Configuration
//   MULT_STREAM_ACC_EN  when defined, the FIFO stores a running 64-bit sum of products
//                       instead of the raw product; in_clr_acc restarts the sum.

module mult32x32_stream_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
`ifdef MULT_STREAM_ACC_EN
    input  logic                     in_clr_acc,
`endif
    output logic                     mul_start,
    output logic [31:0]              mul_a,
    output logic [31:0]              mul_b,
    input  logic                     mul_busy,
    input  logic [63:0]              mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_product,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitHi, StWaitLo} state_e;

    state_e          state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [63:0]     mem_q [DEPTH];
    logic            push;
    logic            pop;
    logic [63:0]     push_data;

`ifdef MULT_STREAM_ACC_EN
    logic            clr_q, clr_d;
    logic [63:0]     acc_q, acc_d;
`endif

    // Sequencer: one operation in flight, FIFO space reserved at accept time.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        push      = 1'b0;
`ifdef MULT_STREAM_ACC_EN
        clr_d     = clr_q;
`endif
        unique case (state_q)
            StIdle: begin
                in_ready = (count_q < CW'(DEPTH));
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
`ifdef MULT_STREAM_ACC_EN
                    clr_d   = in_clr_acc;
`endif
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mul_start = 1'b1;
                state_d   = StWaitHi;
            end
            StWaitHi: begin
                if (mul_busy) state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!mul_busy) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef MULT_STREAM_ACC_EN
    always_comb begin
        push_data = (clr_q ? 64'd0 : acc_q) + mul_product;
        acc_d     = push ? push_data : acc_q;
    end
`else
    assign push_data = mul_product;
`endif

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    // Storage is not reset; the head is masked to zero while the FIFO is empty.
    assign out_product = out_valid ? mem_q[rd_ptr_q] : 64'd0;
    assign out_count   = count_q;
    assign mul_a       = a_q;
    assign mul_b       = b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef MULT_STREAM_ACC_EN
            clr_q    <= 1'b0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef MULT_STREAM_ACC_EN
            clr_q    <= clr_d;
            acc_q    <= acc_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: tb/tb_mult32x32_stream_ctrl.sv
module tb_mult32x32_stream_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int          LAT   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
`ifdef MULT_STREAM_ACC_EN
    logic        in_clr_acc;
`endif
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_busy;
    logic [63:0] mul_product;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic [$clog2(DEPTH):0] out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult32x32_stream_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
`ifdef MULT_STREAM_ACC_EN
        .in_clr_acc  (in_clr_acc),
`endif
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_busy    (mul_busy),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_count   (out_count)
    );

    // Behavioural multiplier: busy for LAT cycles starting the cycle after start.
    logic [31:0] m_a, m_b;
    int          m_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_busy    <= 1'b0;
            mul_product <= 64'd0;
            m_cnt       <= 0;
            m_a         <= 32'd0;
            m_b         <= 32'd0;
        end else if (mul_start) begin
            mul_busy <= 1'b1;
            m_cnt    <= LAT;
            m_a      <= mul_a;
            m_b      <= mul_b;
        end else if (mul_busy) begin
            if (m_cnt == 1) begin
                mul_busy    <= 1'b0;
                mul_product <= {32'd0, m_a} * {32'd0, m_b};
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Free-running event counters; tests take differences.
    int start_total = 0;
    int valid_total = 0;
    int start_busy  = 0;
    always @(posedge clk) begin
        if (mul_start) start_total <= start_total + 1;
        if (out_valid) valid_total <= valid_total + 1;
        if (mul_start && mul_busy) start_busy <= start_busy + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic clr);
        bit done = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
`ifdef MULT_STREAM_ACC_EN
        in_clr_acc = clr;
`else
        if (clr) $display("note: clr ignored without accumulator");
`endif
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            $display("FAIL send_timeout a=%h b=%h in_ready never rose", a, b);
            $fatal(1, "send timeout");
        end
    endtask

    task automatic wait_valid();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (out_valid) done = 1;
            else tick();
        end
        if (!done) begin
            $display("FAIL wait_valid_timeout out_valid never rose");
            $fatal(1, "out_valid timeout");
        end
    endtask

    task automatic wait_busy(input logic level);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (mul_busy == level) done = 1;
            else tick();
        end
        if (!done) begin
            $display("FAIL wait_busy_timeout level=%0b", level);
            $fatal(1, "busy timeout");
        end
    endtask

    task automatic wait_count(input int n);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (out_count == n) done = 1;
            else tick();
        end
        if (!done) begin
            $display("FAIL wait_count_timeout got=%0d want=%0d", out_count, n);
            $fatal(1, "count timeout");
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b0;
`ifdef MULT_STREAM_ACC_EN
        in_clr_acc = 1'b0;
`endif
        repeat (3) tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start got=%b want=0", mul_start); end
        checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin errors++; $display("FAIL rst_mul_ab got=%h/%h want=0/0", mul_a, mul_b); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        checks++; if (out_product !== 64'd0) begin errors++; $display("FAIL rst_out_product got=%h want=0", out_product); end
        checks++; if (out_count !== '0) begin errors++; $display("FAIL rst_out_count got=%0d want=0", out_count); end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single();
        int s0, v0;
        out_ready = 1'b1;
        s0 = start_total;
        v0 = valid_total;
        send(32'd3, 32'd5, 1'b0);
        // First cycle after the accept edge is the start cycle.
        checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL single_start_timing got=%b want=1", mul_start); end
        checks++; if (mul_a !== 32'd3 || mul_b !== 32'd5) begin errors++; $display("FAIL single_mul_ab got=%h/%h want=3/5", mul_a, mul_b); end
        wait_valid();
        checks++; if (out_product !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL single_product got=%h want=f", out_product); end
        repeat (10) tick();
        checks++; if (start_total - s0 !== 1) begin errors++; $display("FAIL single_start_pulses got=%0d want=1", start_total - s0); end
        checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles got=%0d want=1", valid_total - v0); end
    endtask

    task automatic test_extremes();
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_valid();
        checks++; if (out_product !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL extreme_max got=%h want=fffffffe00000001", out_product); end
        tick();
        send(32'd0, 32'h1234_5678, 1'b0);
        wait_valid();
        checks++; if (out_product !== 64'd0) begin errors++; $display("FAIL extreme_zero got=%h want=0", out_product); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(32'd2, 32'd3, 1'b0);
        send(32'd4, 32'd5, 1'b0);
        wait_count(2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
        // Offer the third pair while full: it must not be accepted.
        in_valid = 1'b1;
        in_a     = 32'd6;
        in_b     = 32'd7;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0 || out_count !== 2) begin errors++; $display("FAIL bp_held got=%b/%0d want=0/2", in_ready, out_count); end
        checks++; if (out_product !== 64'd6) begin errors++; $display("FAIL bp_head0 got=%0d want=6", out_product); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_count !== 1) begin errors++; $display("FAIL bp_recover got=%b/%0d want=1/1", in_ready, out_count); end
        send(32'd6, 32'd7, 1'b0);
        checks++; if (out_product !== 64'd20) begin errors++; $display("FAIL bp_head1 got=%0d want=20", out_product); end
        out_ready = 1'b1;
        tick();
        wait_valid();
        checks++; if (out_product !== 64'd42) begin errors++; $display("FAIL bp_head2 got=%0d want=42", out_product); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_count !== 0) begin errors++; $display("FAIL bp_drained got=%0d want=0", out_count); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        send(32'd5, 32'd5, 1'b0);
        wait_count(1);
        send(32'd3, 32'd7, 1'b0);
        wait_busy(1'b1);
        wait_busy(1'b0);
        // This is the push cycle; pop the head in the same cycle.
        out_ready = 1'b1;
        checks++; if (out_product !== 64'd25) begin errors++; $display("FAIL simul_head_before got=%0d want=25", out_product); end
        tick();
        checks++; if (out_count !== 1) begin errors++; $display("FAIL simul_count got=%0d want=1", out_count); end
        checks++; if (out_product !== 64'd21) begin errors++; $display("FAIL simul_head_after got=%0d want=21", out_product); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int v0;
        out_ready = 1'b1;
        send(32'd9, 32'd9, 1'b0);
        wait_busy(1'b1);
        tick();
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || mul_start !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got=%b/%b want=1/0", in_ready, mul_start); end
        checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin errors++; $display("FAIL midrst_mul_ab got=%h/%h want=0/0", mul_a, mul_b); end
        checks++; if (out_valid !== 1'b0 || out_count !== 0 || out_product !== 64'd0) begin errors++; $display("FAIL midrst_fifo got=%b/%0d/%h want=0/0/0", out_valid, out_count, out_product); end
        repeat (2) tick();
        reset = 1'b1;
        v0 = valid_total;
        repeat (20) tick();
        checks++; if (valid_total - v0 !== 0) begin errors++; $display("FAIL midrst_no_result got=%0d want=0", valid_total - v0); end
        send(32'd7, 32'd9, 1'b0);
        wait_valid();
        checks++; if (out_product !== 64'd63) begin errors++; $display("FAIL midrst_next got=%0d want=63", out_product); end
        tick();
    endtask

`ifdef MULT_STREAM_ACC_EN
    task automatic test_acc();
        out_ready = 1'b1;
        send(32'd2, 32'd3, 1'b1);
        wait_valid();
        checks++; if (out_product !== 64'd6) begin errors++; $display("FAIL acc_first got=%0d want=6", out_product); end
        tick();
        send(32'd4, 32'd5, 1'b0);
        wait_valid();
        checks++; if (out_product !== 64'd26) begin errors++; $display("FAIL acc_sum got=%0d want=26", out_product); end
        tick();
        send(32'd1, 32'd1, 1'b1);
        wait_valid();
        checks++; if (out_product !== 64'd1) begin errors++; $display("FAIL acc_clear got=%0d want=1", out_product); end
        tick();
    endtask
`endif

    task automatic test_start_never_busy();
        checks++; if (start_busy !== 0) begin errors++; $display("FAIL start_while_busy got=%0d want=0", start_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_backpressure();
        test_simultaneous();
        test_reset_midop();
`ifdef MULT_STREAM_ACC_EN
        // Clear the accumulator history left by earlier tests.
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        test_acc();
`endif
        test_start_never_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult32x32_stream_ctrl.md
# mult32x32_stream_ctrl

- Streaming front/back end for the 32x32 iterative multiplier.
- Accepts operand pairs over a valid/ready handshake and sequences one multiplication at a time through the multiplier's start/busy interface.
- Buffers the 64-bit products in a small result FIFO and presents them downstream over a second valid/ready handshake.
- Sits between the operand producer and the result consumer, with the multiplier instance alongside it.

## Interface

Parameters:
- DEPTH, 2, result FIFO entries; power of two, ≥2

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous reset, active-low (0 = reset asserted)
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operand pair this cycle
- in_a  input  32  multiplicand
- in_b  input  32  multiplier
- mul_start  output  1  one-cycle start pulse to multiplier
- mul_a  output  32  operand a to multiplier, registered
- mul_b  output  32  operand b to multiplier, registered
- mul_busy  input  1  multiplier busy indication
- mul_product  input  64  multiplier product, valid when mul_busy falls
- out_valid  output  1  FIFO head holds a result
- out_ready  input  1  consumer takes head this cycle
- out_product  output  64  FIFO head result
- out_count  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation

- FSM states:
  - IDLE: in_ready = (out_count < DEPTH). An accept (in_valid & in_ready) latches in_a/in_b into mul_a/mul_b and moves to ISSUE.
  - ISSUE: mul_start = 1 for exactly this cycle, then WAIT_HI.
  - WAIT_HI: hold until mul_busy = 1, then WAIT_LO.
  - WAIT_LO: hold until mul_busy = 0. That cycle, mul_product is pushed into the FIFO and the FSM returns to IDLE.
- in_ready is 0 in ISSUE/WAIT_HI/WAIT_LO, so only one operation is in flight.
- mul_a/mul_b stay stable from accept until the FSM returns to IDLE.
- Space is reserved at accept: in_ready requires a free FIFO entry, so a push can never overflow.
- FIFO:
  - out_valid = (out_count != 0); out_product = head entry. The head is stable while out_valid & !out_ready.
  - Pop when out_valid & out_ready.
  - Pop and push in the same cycle: out_count unchanged, and the new entry goes to the tail.
  - out_ready while empty is ignored.
  - Read/write pointers wrap modulo DEPTH.
- Products pass through unchanged: full 64-bit unsigned result, no truncation.
- Reset (asynchronous, any state, including mid-multiplication):
  - State forced to IDLE; FIFO emptied.
  - Outputs: in_ready = 1, mul_start = 0, mul_a = 0, mul_b = 0, out_valid = 0, out_product = 0, out_count = 0.
  - An in-flight result is discarded. The multiplier shares this reset.

## Timing

- Accept at edge T → mul_start = 1 during cycle T+1.
- Multiplier raises busy at T+2 or later.
- Falling edge of busy seen at cycle F → push at the edge ending F → out_valid = 1 from F+1 (when the FIFO was empty).
- Next accept is possible in cycle F+1, since in_ready is combinational from state and count.
- Throughput: one operation per (multiplier latency + 3) cycles.
- FIFO full (out_count = DEPTH): in_ready = 0 in IDLE. It recovers the cycle after a pop.
- mul_start never asserts while mul_busy = 1.

## Configuration

- Macro MULT_STREAM_ACC_EN.
- Defined:
  - Adds input in_clr_acc (1 bit, sampled with the operand accept) and a 64-bit accumulator register.
  - On push, the accumulator is updated to (in_clr_acc_latched ? 0 : acc) + mul_product, modulo 2^64.
  - The FIFO stores the updated accumulator value instead of the raw product.
  - Reset clears the accumulator to 0.
- Undefined: no accumulator, no in_clr_acc port; the FIFO stores the raw mul_product.

## Test plan

- **Single op:** reset released, in_a = 0x0000_0003, in_b = 0x0000_0005, out_ready = 1 → exactly one mul_start pulse; out_product = 0x0000_0000_0000_000F with out_valid for one cycle.
- **Extremes:** in_a = in_b = 0xFFFF_FFFF → out_product = 0xFFFF_FFFE_0000_0001. Then in_a = 0, in_b = 0x1234_5678 → out_product = 0.
- **Backpressure:** out_ready = 0 and DEPTH = 2, send 3 pairs (2×3, 4×5, 6×7) → in_ready = 0 after 2 results and out_count = 2. Raising out_ready drains 6, 20, 42 in order with the third accepted after the first pop.
- **Simultaneous push/pop:** with out_count = 1 and out_ready = 1 on the push cycle → out_count stays 1, and the order is preserved.
- **Reset mid-op:** assert reset during WAIT_LO → outputs take their reset values immediately; no result appears after release; the next pair 7×9 gives 63.
- **MULT_STREAM_ACC_EN:** pairs 2×3 (clr = 1), 4×5, 1×1 (clr = 1) → outputs 6, 26, 1.
